// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Package : seq_mult_pkg
// Brief   : Shared defaults and state encoding for the seq_mult issue block.
// Revision: 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    localparam int unsigned C_WIDTH   = 8;
    localparam int unsigned C_TIMEOUT = 32;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_START = C_ST_START,
        ST_WAIT  = C_ST_WAIT,
        ST_HOLD  = C_ST_HOLD
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_mult_fifo.sv
`default_nettype none
// ============================================================================
// Module  : seq_mult_fifo
// Brief   : Synchronous FIFO holding packed {a, b} operand pairs.
// Revision: 1.0 - initial release
// ============================================================================
module seq_mult_fifo
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = C_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [2*WIDTH-1:0]     din,
    output logic [2*WIDTH-1:0]     dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned C_AW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] r_mem_q [DEPTH];
    logic [C_AW-1:0]    r_wptr_q, w_wptr_d;
    logic [C_AW-1:0]    r_rptr_q, w_rptr_d;
    logic [C_AW:0]      r_count_q, w_count_d;

    // Pointers are exactly C_AW bits wide, so they wrap mod DEPTH for free.
    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (push) w_wptr_d = r_wptr_q + 1'b1;
        if (pop)  w_rptr_d = r_rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem_q[r_wptr_q] <= din;
    end

    assign dout  = r_mem_q[r_rptr_q];
    assign count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/seq_mult_issue.sv
`default_nettype none
// ============================================================================
// Module  : seq_mult_issue
// Brief   : Buffers signed operand pairs, issues them one at a time to
//           seq_mult and returns each product with its operands, in order.
// Options : SEQ_MULT_TIMEOUT_EN adds a WAIT watchdog and the out_err port.
// Revision: 1.0 - initial release
// ============================================================================
module seq_mult_issue
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH   = C_WIDTH,
`ifdef SEQ_MULT_TIMEOUT_EN
    parameter int unsigned TIMEOUT = C_TIMEOUT,
`endif
    parameter int unsigned DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_p,
    input  logic                 mult_rdy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic                 busy
`ifdef SEQ_MULT_TIMEOUT_EN
    ,
    output logic                 out_err
`endif
);

    localparam int unsigned C_CW = $clog2(DEPTH) + 1;

    logic [C_CW-1:0]    w_count;
    logic [2*WIDTH-1:0] w_fifo_dout;
    logic               w_push, w_pop;

    state_e             r_state_q, w_state_d;
    logic               r_mult_start_q, w_mult_start_d;
    logic [WIDTH-1:0]   r_mult_a_q, w_mult_a_d;
    logic [WIDTH-1:0]   r_mult_b_q, w_mult_b_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [2*WIDTH-1:0] r_out_p_q, w_out_p_d;
    logic [WIDTH-1:0]   r_out_a_q, w_out_a_d;
    logic [WIDTH-1:0]   r_out_b_q, w_out_b_d;
`ifdef SEQ_MULT_TIMEOUT_EN
    localparam int unsigned C_TW = $clog2(TIMEOUT + 1);
    logic [C_TW-1:0]    r_tmo_q, w_tmo_d;
    logic               r_out_err_q, w_out_err_d;
`endif

    // No push-through: a full FIFO refuses input even on a pop cycle.
    assign in_ready = (w_count < C_CW'(DEPTH));
    assign w_push   = in_valid & in_ready;

    seq_mult_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({in_a, in_b}),
        .dout  (w_fifo_dout),
        .count (w_count)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_mult_start_d = r_mult_start_q;
        w_mult_a_d     = r_mult_a_q;
        w_mult_b_d     = r_mult_b_q;
        w_out_valid_d  = r_out_valid_q;
        w_out_p_d      = r_out_p_q;
        w_out_a_d      = r_out_a_q;
        w_out_b_d      = r_out_b_q;
        w_pop          = 1'b0;
`ifdef SEQ_MULT_TIMEOUT_EN
        w_tmo_d        = r_tmo_q;
        w_out_err_d    = r_out_err_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (w_count != '0) begin
                    w_pop          = 1'b1;
                    w_mult_a_d     = w_fifo_dout[2*WIDTH-1:WIDTH];
                    w_mult_b_d     = w_fifo_dout[WIDTH-1:0];
                    w_mult_start_d = 1'b1;
                    w_state_d      = ST_START;
                end
            end
            ST_START: begin
                w_mult_start_d = 1'b0;
                w_state_d      = ST_WAIT;
`ifdef SEQ_MULT_TIMEOUT_EN
                w_tmo_d        = '0;
`endif
            end
            ST_WAIT: begin
                // rdy is only trusted here; anything seen earlier is stale.
                if (mult_rdy) begin
                    w_out_p_d     = mult_p;
                    w_out_a_d     = r_mult_a_q;
                    w_out_b_d     = r_mult_b_q;
                    w_out_valid_d = 1'b1;
                    w_state_d     = ST_HOLD;
`ifdef SEQ_MULT_TIMEOUT_EN
                    w_out_err_d   = 1'b0;
                end else if (r_tmo_q == C_TW'(TIMEOUT - 1)) begin
                    w_out_p_d     = '0;
                    w_out_a_d     = r_mult_a_q;
                    w_out_b_d     = r_mult_b_q;
                    w_out_err_d   = 1'b1;
                    w_out_valid_d = 1'b1;
                    w_state_d     = ST_HOLD;
                end else begin
                    w_tmo_d       = r_tmo_q + 1'b1;
`endif
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_mult_start_q <= 1'b0;
            r_mult_a_q     <= '0;
            r_mult_b_q     <= '0;
            r_out_valid_q  <= 1'b0;
            r_out_p_q      <= '0;
            r_out_a_q      <= '0;
            r_out_b_q      <= '0;
`ifdef SEQ_MULT_TIMEOUT_EN
            r_tmo_q        <= '0;
            r_out_err_q    <= 1'b0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_mult_start_q <= w_mult_start_d;
            r_mult_a_q     <= w_mult_a_d;
            r_mult_b_q     <= w_mult_b_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_p_q      <= w_out_p_d;
            r_out_a_q      <= w_out_a_d;
            r_out_b_q      <= w_out_b_d;
`ifdef SEQ_MULT_TIMEOUT_EN
            r_tmo_q        <= w_tmo_d;
            r_out_err_q    <= w_out_err_d;
`endif
        end
    end

    assign mult_start = r_mult_start_q;
    assign mult_a     = r_mult_a_q;
    assign mult_b     = r_mult_b_q;
    assign out_valid  = r_out_valid_q;
    assign out_p      = r_out_p_q;
    assign out_a      = r_out_a_q;
    assign out_b      = r_out_b_q;
    assign busy       = (r_state_q != ST_IDLE) || (w_count != '0);
`ifdef SEQ_MULT_TIMEOUT_EN
    assign out_err    = r_out_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_mult_issue
// Brief   : Self-checking bench: behavioural multiplier, queue scoreboard,
//           directed cases and randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_mult_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b;
    logic        mult_start;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] mult_p = '0;
    logic        mult_rdy = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic [7:0]  out_a, out_b;
    logic        busy;
`ifdef SEQ_MULT_TIMEOUT_EN
    logic        out_err;
`endif

    always #5 clk = ~clk;

    seq_mult_issue dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_p     (mult_p),
        .mult_rdy   (mult_rdy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_a      (out_a),
        .out_b      (out_b),
        .busy       (busy)
`ifdef SEQ_MULT_TIMEOUT_EN
        ,
        .out_err    (out_err)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          n_start = 0;
    int          mul_lat = 3;
    bit          m_hang = 1'b0;
    bit          exp_timeout = 1'b0;
    bit          rand_or = 1'b0;
    int          dummy;
    logic [15:0] exp_q[$];
    logic [15:0] got_p[$];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural seq_mult: start restarts it; rdy rises after a latency and
    // stays high until the next start, exactly like the real unit.
    wire signed [15:0] m_prod = $signed(mult_a) * $signed(mult_b);
    int m_cnt = 0;
    bit m_armed = 1'b0;
    always @(posedge clk) begin
        if (mult_start) begin
            m_cnt    <= (mul_lat > 0) ? mul_lat : int'($urandom_range(0, 6));
            mult_rdy <= 1'b0;
            m_armed  <= 1'b1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end else if (m_armed && !m_hang) begin
            mult_rdy <= 1'b1;
            mult_p   <= m_prod;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: every accepted pair must come back once, in order, as a*b.
    initial begin
        logic [15:0]        e;
        logic signed [63:0] ep;
        bit                 prev_v, prev_r, prev_start;
        logic [15:0]        prev_p;
        logic [7:0]         prev_a, prev_b;
        prev_v = 0; prev_r = 0; prev_start = 0;
        prev_p = '0; prev_a = '0; prev_b = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_v = 0;
                prev_start = 0;
            end else begin
                if (mult_start) begin
                    n_start++;
                    chk("start_width", prev_start, 0);
                    chk("start_during_hold", out_valid, 0);
                end
                if (prev_v && !prev_r) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_p", out_p, prev_p);
                    chk("hold_a", out_a, prev_a);
                    chk("hold_b", out_b, prev_b);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (exp_timeout) ep = 0;
                        else ep = $signed(e[15:8]) * $signed(e[7:0]);
                        chk("out_p", $signed(out_p), ep);
                        chk("out_a", $signed(out_a), $signed(e[15:8]));
                        chk("out_b", $signed(out_b), $signed(e[7:0]));
`ifdef SEQ_MULT_TIMEOUT_EN
                        chk("out_err", out_err, exp_timeout);
`endif
                        got_p.push_back(out_p);
                    end
                end
                if (in_valid && in_ready) exp_q.push_back({in_a, in_b});
                prev_v = out_valid;
                prev_r = out_ready;
                prev_p = out_p;
                prev_a = out_a;
                prev_b = out_b;
                prev_start = mult_start;
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b, output int stalls);
        stalls = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        while (!in_ready && stalls < 500) begin
            stalls++;
            @(negedge clk);
        end
        chk("push_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int bound);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < bound) begin
            n++;
            @(negedge clk);
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic wait_start(input int bound);
        int n = 0;
        @(negedge clk);
        while (!mult_start && n < bound) begin
            n++;
            @(negedge clk);
        end
        chk("wait_mult_start", mult_start, 1);
    endtask

    task automatic wait_got(input int target, input int bound);
        int n = 0;
        @(negedge clk);
        while (got_p.size() < target && n < bound) begin
            n++;
            @(negedge clk);
        end
        chk("wait_results", got_p.size(), target);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lit [4];
        int          s0, s1, g0, st, n;
        bit          saw_v;
        lit = '{16'hFFEC, 16'hFFEC, 16'h0000, 16'h4000};

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);

        // Single pair with latency check.
        align();
        s0 = n_start;
        push(8'd10, 8'd2, dummy);
        @(negedge clk);
        chk("lat_after_e0", mult_start, 0);
        @(negedge clk);
        chk("lat_after_e1", mult_start, 1);
        wait_out(100);
        chk("single_p", $signed(out_p), 20);
        chk("single_a", out_a, 10);
        chk("single_b", out_b, 2);
        repeat (2) @(negedge clk);
        chk("single_busy_done", busy, 0);
        chk("single_one_pulse", n_start - s0, 1);

        // Signed corner cases.
        align();
        g0 = got_p.size();
        push(8'hF6, 8'd2, dummy);
        push(8'd10, 8'hFE, dummy);
        push(8'd0, 8'd5, dummy);
        push(8'h80, 8'h80, dummy);
        wait_got(g0 + 4, 300);
        for (int i = 0; i < 4; i++) chk("signed_lit", got_p[g0 + i], lit[i]);

        // Back-to-back squares fill the FIFO.
        align();
        mul_lat = 4;
        g0 = got_p.size();
        for (int i = 1; i <= 6; i++) begin
            push(8'(i), 8'(i), st);
            if (i == 6) chk("full_stalls_pair6", st > 0, 1);
        end
        wait_got(g0 + 6, 400);
        for (int i = 0; i < 6; i++) chk("square", got_p[g0 + i], (i + 1) * (i + 1));

        // Consumer stalls: result held, no issue, FIFO fills to DEPTH.
        align();
        mul_lat = 3;
        out_ready = 1'b0;
        g0 = got_p.size();
        push(8'd3, 8'd5, dummy);
        push(8'd1, 8'd2, dummy);
        push(8'd2, 8'd2, dummy);
        push(8'd3, 8'd3, dummy);
        push(8'd4, 8'd4, dummy);
        wait_out(100);
        s1 = n_start;
        repeat (20) @(negedge clk);
        chk("stall_no_start", n_start, s1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_valid", out_valid, 1);
        chk("stall_p", out_p, 15);
        chk("stall_busy", busy, 1);
        align();
        out_ready = 1'b1;
        wait_got(g0 + 5, 300);

        // Reset during WAIT; the late rdy must be ignored.
        align();
        mul_lat = 12;
        push(8'd7, 8'd3, dummy);
        wait_start(50);
        align();
        align();
        align();
        reset = 1'b1;
        align();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wait_valid", out_valid, 0);
        chk("rst_wait_busy", busy, 0);
        chk("rst_wait_in_ready", in_ready, 1);
        saw_v = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) saw_v = 1'b1;
        end
        chk("stale_rdy_ignored", saw_v, 0);
        align();
        mul_lat = 3;
        g0 = got_p.size();
        push(8'hFB, 8'd6, dummy);
        wait_got(g0 + 1, 100);
        chk("after_reset_p", $signed(got_p[g0]), -30);

        // Randomized traffic with random latency and back-pressure.
        align();
        mul_lat = 0;
        rand_or = 1'b1;
        for (int i = 0; i < 150; i++) begin
            push(8'($urandom), 8'($urandom), dummy);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) align();
        end
        wait_idle(3000);
        rand_or = 1'b0;
        align();
        out_ready = 1'b1;

`ifdef SEQ_MULT_TIMEOUT_EN
        // Hung multiplier: watchdog fires TIMEOUT cycles after WAIT entry.
        mul_lat = 3;
        m_hang = 1'b1;
        exp_timeout = 1'b1;
        push(8'd9, 8'd9, dummy);
        wait_start(50);
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 100);
        chk("tmo_latency", n, 32);
        chk("tmo_err", out_err, 1);
        chk("tmo_p", out_p, 0);
        chk("tmo_a", out_a, 9);
        align();
        exp_timeout = 1'b0;
        m_hang = 1'b0;
        push(8'd2, 8'd3, dummy);
        wait_out(100);
        chk("post_tmo_err", out_err, 0);
        chk("post_tmo_p", out_p, 6);
        wait_idle(100);
`else
        n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
